mem_port_arbiter: RTL and testbench

Arbitrates one single-port synchronous RAM between the instruction-fetch port (IF) and the data-memory port (MEM stage, fed by the EX/MEM pipeline register).
Sequences each RAM access through a small FSM with a configurable read latency and returns data and a one-cycle ack to the owner.
Generates stall signals that freeze the IF/ID and EX/MEM stages while their access is pending.

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the instruction-fetch port
// (IF, read only) and the data-memory port (MEM, read or write). Each access
// is sequenced by a small FSM:
//   IDLE -> ISSUE -> [WAIT ...] -> CAPTURE -> RESP -> IDLE
// The RAM sees exactly one ram_en cycle per grant, read data is captured
// RAM_LAT cycles after that strobe, and the owner gets a one-cycle ack.
// Ties are broken round-robin against the last completed owner, so MEM wins
// the first tie after reset.
//
// Parameters:
//   AW       address width
//   DW       data width
//   RAM_LAT  cycles from the ram_en cycle to ram_rdata valid (1..8)
//
// Ports:
//   clk, resetn                  clock / asynchronous active-low reset
//   if_req, if_addr              IF read request (level, held until if_ack)
//   if_rdata, if_ack             IF read data (held) and completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    MEM request (level, held until mem_ack)
//   mem_rdata, mem_ack           MEM read data (held) and completion pulse
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata         single-port RAM interface
//   stall_if, stall_mem          pipeline freezes while a request is pending
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  // Wide enough for the largest legal latency; never wraps.
  localparam int CW = $clog2(8) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_cnt;
  logic          r_owner_mem;   // 1 = MEM owns the current access
  logic          r_last_mem;    // 1 = last completed access was MEM
  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;
  logic          r_if_ack;
  logic          r_mem_ack;

  logic          w_grant;
  logic          w_grant_mem;
  logic          w_capture_done;

  // A grant is only taken in IDLE. On a tie the port that did not go last
  // wins; r_last_mem resets to IF so MEM takes the first tie.
  assign w_grant     = (r_state == S_IDLE) && (if_req || mem_req);
  assign w_grant_mem = mem_req && (!if_req || !r_last_mem);
  assign w_capture_done = (r_state == S_CAPTURE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = (RAM_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        // cnt was loaded with RAM_LAT-1 at grant; leaving when it reads 1
        // lands CAPTURE exactly RAM_LAT cycles after the ram_en cycle.
        if (r_cnt == CW'(1)) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_state_next = S_RESP;
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: request snapshot, RAM strobe, read data and acks
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_owner_mem <= 1'b0;
      r_last_mem  <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
    end else begin
      // ram_en is high only in the ISSUE cycle that follows a grant.
      r_ram_en <= w_grant;

      if (w_grant) begin
        r_owner_mem <= w_grant_mem;
        r_cnt       <= CW'(RAM_LAT - 1);
        if (w_grant_mem) begin
          r_ram_addr  <= mem_addr;
          r_ram_we    <= mem_we;
          r_ram_wdata <= mem_wdata;
        end else begin
          // IF is read only; ram_wdata keeps its previous value.
          r_ram_addr <= if_addr;
          r_ram_we   <= 1'b0;
        end
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end

      // ram_rdata is valid during CAPTURE; writes leave rdata untouched.
      if (w_capture_done && !r_ram_we) begin
        if (r_owner_mem) begin
          r_mem_rdata <= ram_rdata;
        end else begin
          r_if_rdata <= ram_rdata;
        end
      end

      if (w_capture_done) begin
        r_last_mem <= r_owner_mem;
      end

      // Acks are high during RESP only; only one owner exists at a time, so
      // the two acks can never overlap.
      r_if_ack  <= w_capture_done && !r_owner_mem;
      r_mem_ack <= w_capture_done &&  r_owner_mem;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign mem_rdata = r_mem_rdata;
  assign mem_ack   = r_mem_ack;

  assign stall_if  = if_req  && !r_if_ack;
  assign stall_mem = mem_req && !r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiter instances share one clock: instance 0 uses RAM_LAT=1,
// instance 1 RAM_LAT=3, instance 2 RAM_LAT=4. Each has its own behavioural
// RAM with the matching read latency. Directed transactions are applied with
// cycle 0 defined as the cycle in which the request is first seen in IDLE;
// outputs are sampled on the falling edge and logged per cycle, then compared
// against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NI   = 3;
  localparam int NLOG = 20;

  logic        clk;
  logic        resetn    [NI];
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic [31:0] if_rdata  [NI];
  logic        if_ack    [NI];
  logic        mem_req   [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        mem_ack   [NI];
  logic        ram_en    [NI];
  logic        ram_we    [NI];
  logic [31:0] ram_addr  [NI];
  logic [31:0] ram_wdata [NI];
  logic        stall_if  [NI];
  logic        stall_mem [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle logs of the instance under test
  logic        lg_en     [NLOG];
  logic        lg_we     [NLOG];
  logic [31:0] lg_addr   [NLOG];
  logic [31:0] lg_wdata  [NLOG];
  logic        lg_ifack  [NLOG];
  logic        lg_memack [NLOG];
  logic        lg_sif    [NLOG];
  logic        lg_smem   [NLOG];
  logic [31:0] lg_ifrd   [NLOG];
  logic [31:0] lg_memrd  [NLOG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT instances with behavioural RAMs
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);

      logic [31:0] mem  [256];
      logic [31:0] pipe [LAT];

      // Word-indexed RAM: word i holds 0xC0DE_0000+i, except address 0x100
      // (word 0x40) which holds 0xDEADBEEF.
      initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[8'h40] = 32'hDEAD_BEEF;
      end

      always @(posedge clk) begin
        pipe[0] <= ram_en[gi] ? mem[ram_addr[gi][9:2]] : 32'h0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (ram_en[gi] && ram_we[gi]) mem[ram_addr[gi][9:2]] <= ram_wdata[gi];
      end

      mem_port_arbiter #(
        .AW     (32),
        .DW     (32),
        .RAM_LAT(LAT)
      ) u_dut (
        .clk      (clk),
        .resetn   (resetn[gi]),
        .if_req   (if_req[gi]),
        .if_addr  (if_addr[gi]),
        .if_rdata (if_rdata[gi]),
        .if_ack   (if_ack[gi]),
        .mem_req  (mem_req[gi]),
        .mem_we   (mem_we[gi]),
        .mem_addr (mem_addr[gi]),
        .mem_wdata(mem_wdata[gi]),
        .mem_rdata(mem_rdata[gi]),
        .mem_ack  (mem_ack[gi]),
        .ram_en   (ram_en[gi]),
        .ram_we   (ram_we[gi]),
        .ram_addr (ram_addr[gi]),
        .ram_wdata(ram_wdata[gi]),
        .ram_rdata(pipe[LAT-1]),
        .stall_if (stall_if[gi]),
        .stall_mem(stall_mem[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reset every instance; while reset is held, check the reset state of inst.
  task automatic do_reset(input int inst);
    for (int i = 0; i < NI; i++) begin
      resetn[i]    = 1'b0;
      if_req[i]    = 1'b0;
      if_addr[i]   = '0;
      mem_req[i]   = 1'b0;
      mem_we[i]    = 1'b0;
      mem_addr[i]  = '0;
      mem_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_ram_en",    {31'd0, ram_en[inst]},  32'd0);
    check_value("rst_ram_we",    {31'd0, ram_we[inst]},  32'd0);
    check_value("rst_ram_addr",  ram_addr[inst],         32'd0);
    check_value("rst_ram_wdata", ram_wdata[inst],        32'd0);
    check_value("rst_if_ack",    {31'd0, if_ack[inst]},  32'd0);
    check_value("rst_mem_ack",   {31'd0, mem_ack[inst]}, 32'd0);
    check_value("rst_if_rdata",  if_rdata[inst],         32'd0);
    check_value("rst_mem_rdata", mem_rdata[inst],        32'd0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) resetn[i] = 1'b1;
  endtask

  // Log n cycles of inst on falling edges. With drop set, a requester drops
  // its request in the cycle its ack is seen. At log cycle chg_k the MEM
  // address is overwritten with chg_addr (chg_k < 0 disables).
  task automatic run(input int inst, input int n, input bit drop,
                     input int chg_k, input logic [31:0] chg_addr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      lg_en[k]     = ram_en[inst];
      lg_we[k]     = ram_we[inst];
      lg_addr[k]   = ram_addr[inst];
      lg_wdata[k]  = ram_wdata[inst];
      lg_ifack[k]  = if_ack[inst];
      lg_memack[k] = mem_ack[inst];
      lg_sif[k]    = stall_if[inst];
      lg_smem[k]   = stall_mem[inst];
      lg_ifrd[k]   = if_rdata[inst];
      lg_memrd[k]  = mem_rdata[inst];
      if (drop && if_ack[inst]) if_req[inst] = 1'b0;
      if (drop && mem_ack[inst]) begin
        mem_req[inst] = 1'b0;
        mem_we[inst]  = 1'b0;
      end
      if (k == chg_k) mem_addr[inst] = chg_addr;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    int cnt;
    logic [1:0] acks;
    logic [1:0] acks_exp;

    // --- T1: single IF read, RAM_LAT=1 -------------------------------------
    do_reset(0);
    @(posedge clk); #1;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0100;
    run(0, 6, 1'b1, -1, '0);
    $display("txn T1: IF read 0x100 lat=1 ack@3 rdata=0x%08h", lg_ifrd[3]);
    check_value("t1_en_c0",    {31'd0, lg_en[0]},    32'd0);
    check_value("t1_en_c1",    {31'd0, lg_en[1]},    32'd1);
    check_value("t1_en_c2",    {31'd0, lg_en[2]},    32'd0);
    check_value("t1_addr_c1",  lg_addr[1],           32'h0000_0100);
    check_value("t1_we_c1",    {31'd0, lg_we[1]},    32'd0);
    check_value("t1_ack_c2",   {31'd0, lg_ifack[2]}, 32'd0);
    check_value("t1_ack_c3",   {31'd0, lg_ifack[3]}, 32'd1);
    check_value("t1_ack_c4",   {31'd0, lg_ifack[4]}, 32'd0);
    check_value("t1_rdata_c3", lg_ifrd[3],           32'hDEAD_BEEF);
    check_value("t1_rdata_c5", lg_ifrd[5],           32'hDEAD_BEEF);
    cnt = 0;
    for (int k = 0; k < 3; k++) cnt += int'(lg_sif[k]);
    check_value("t1_stall_c0_2", cnt, 32'd3);
    check_value("t1_stall_c3", {31'd0, lg_sif[3]}, 32'd0);

    // --- T2: simultaneous requests right after reset, RAM_LAT=1 ------------
    do_reset(0);
    @(posedge clk); #1;
    if_req[0]   = 1'b1;
    if_addr[0]  = 32'h0000_0100;
    mem_req[0]  = 1'b1;
    mem_we[0]   = 1'b0;
    mem_addr[0] = 32'h0000_0040;
    run(0, 10, 1'b1, -1, '0);
    $display("txn T2: tie MEM then IF, mem_ack@3 if_ack@7");
    check_value("t2_en_c1",     {31'd0, lg_en[1]},     32'd1);
    check_value("t2_addr_c1",   lg_addr[1],            32'h0000_0040);
    check_value("t2_memack_c3", {31'd0, lg_memack[3]}, 32'd1);
    check_value("t2_ifack_c3",  {31'd0, lg_ifack[3]},  32'd0);
    check_value("t2_memrd_c3",  lg_memrd[3],           32'hC0DE_0010);
    check_value("t2_en_c5",     {31'd0, lg_en[5]},     32'd1);
    check_value("t2_addr_c5",   lg_addr[5],            32'h0000_0100);
    check_value("t2_ifack_c7",  {31'd0, lg_ifack[7]},  32'd1);
    check_value("t2_memack_c7", {31'd0, lg_memack[7]}, 32'd0);
    check_value("t2_ifrd_c7",   lg_ifrd[7],            32'hDEAD_BEEF);
    cnt = 0;
    for (int k = 0; k < 7; k++) cnt += int'(lg_sif[k]);
    check_value("t2_stall_if_c0_6", cnt, 32'd7);

    // --- T3: continuous requests on both ports, 4 transactions -------------
    do_reset(0);
    @(posedge clk); #1;
    if_req[0]   = 1'b1;
    if_addr[0]  = 32'h0000_0100;
    mem_req[0]  = 1'b1;
    mem_addr[0] = 32'h0000_0040;
    run(0, 16, 1'b0, -1, '0);
    if_req[0]  = 1'b0;
    mem_req[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      acks     = {lg_ifack[k], lg_memack[k]};
      acks_exp = {((k % 8) == 7), ((k % 8) == 3)};
      check_value($sformatf("t3_acks_c%0d", k), {30'd0, acks}, {30'd0, acks_exp});
      if (lg_ifack[k] && lg_memack[k]) cnt++;
    end
    check_value("t3_ack_overlap", cnt, 32'd0);
    $display("txn T3: 4 back-to-back grants MEM,IF,MEM,IF");

    // --- T4: MEM write then read-back, RAM_LAT=3 ---------------------------
    do_reset(1);
    @(posedge clk); #1;
    mem_req[1]   = 1'b1;
    mem_we[1]    = 1'b1;
    mem_addr[1]  = 32'h0000_0040;
    mem_wdata[1] = 32'h1234_5678;
    run(1, 8, 1'b1, -1, '0);
    $display("txn T4a: MEM write 0x40=0x12345678 lat=3 ack@5");
    cnt = 0;
    for (int k = 0; k < 8; k++) cnt += int'(lg_en[k]);
    check_value("t4_en_count",  cnt,                   32'd1);
    check_value("t4_en_c1",     {31'd0, lg_en[1]},     32'd1);
    check_value("t4_we_c1",     {31'd0, lg_we[1]},     32'd1);
    check_value("t4_addr_c1",   lg_addr[1],            32'h0000_0040);
    check_value("t4_wdata_c1",  lg_wdata[1],           32'h1234_5678);
    check_value("t4_memack_c4", {31'd0, lg_memack[4]}, 32'd0);
    check_value("t4_memack_c5", {31'd0, lg_memack[5]}, 32'd1);
    check_value("t4_memrd_c5",  lg_memrd[5],           32'd0);

    @(posedge clk); #1;
    mem_req[1]  = 1'b1;
    mem_we[1]   = 1'b0;
    mem_addr[1] = 32'h0000_0040;
    run(1, 8, 1'b1, -1, '0);
    $display("txn T4b: MEM read 0x40 lat=3 rdata=0x%08h", lg_memrd[5]);
    check_value("t4r_we_c1",     {31'd0, lg_we[1]},     32'd0);
    check_value("t4r_memack_c5", {31'd0, lg_memack[5]}, 32'd1);
    check_value("t4r_memrd_c5",  lg_memrd[5],           32'h1234_5678);

    // --- T5: address changes after grant, RAM_LAT=4 ------------------------
    do_reset(2);
    @(posedge clk); #1;
    mem_req[2]  = 1'b1;
    mem_we[2]   = 1'b0;
    mem_addr[2] = 32'h0000_0040;
    run(2, 8, 1'b1, 1, 32'h0000_0080);
    $display("txn T5: MEM read 0x40 lat=4, addr moved to 0x80 in cycle 1");
    check_value("t5_addr_c1",   lg_addr[1],            32'h0000_0040);
    check_value("t5_addr_c6",   lg_addr[6],            32'h0000_0040);
    check_value("t5_memack_c5", {31'd0, lg_memack[5]}, 32'd0);
    check_value("t5_memack_c6", {31'd0, lg_memack[6]}, 32'd1);
    check_value("t5_memrd_c6",  lg_memrd[6],           32'hC0DE_0010);

    // --- T6: reset during WAIT, RAM_LAT=4 ----------------------------------
    @(posedge clk); #1;
    mem_req[2]  = 1'b1;
    mem_we[2]   = 1'b0;
    mem_addr[2] = 32'h0000_0080;
    run(2, 3, 1'b0, -1, '0);
    @(posedge clk); #1;            // cycle 3: WAIT
    resetn[2] = 1'b0;
    #1;
    check_value("t6_rst_en",    {31'd0, ram_en[2]},  32'd0);
    check_value("t6_rst_addr",  ram_addr[2],         32'd0);
    check_value("t6_rst_memrd", mem_rdata[2],        32'd0);
    check_value("t6_rst_ack",   {31'd0, mem_ack[2]}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cnt += int'(mem_ack[2]) + int'(ram_en[2]);
    end
    check_value("t6_no_ack_in_rst", cnt, 32'd0);
    @(posedge clk); #1;
    resetn[2] = 1'b1;              // mem_req still pending: cycle 0
    run(2, 8, 1'b1, -1, '0);
    $display("txn T6: reset in WAIT aborted, pending MEM read 0x80 served");
    check_value("t6_en_c1",     {31'd0, lg_en[1]},     32'd1);
    check_value("t6_addr_c1",   lg_addr[1],            32'h0000_0080);
    check_value("t6_memack_c6", {31'd0, lg_memack[6]}, 32'd1);
    check_value("t6_memrd_c6",  lg_memrd[6],           32'hC0DE_0020);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
